// File: rtl/enc_pkg.sv
// Shared definitions for the event-to-code request queue: default width and
// presentation-state encodings.
package enc_pkg;

  localparam int N_DEF  = 8;
  localparam int CW_DEF = $clog2(N_DEF);

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } q_state_t;

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational highest-set-bit encoder; code is 0 when no bit is set.
module prio_enc_comb #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] code,
  output logic          any
);

  // Scan upward so the highest set index is the last one written.
  always_comb begin
    code = {CW{1'b0}};
    for (int i = 0; i < N; i++) begin
      code = vec[i] ? CW'(i) : code;
    end
    any = |vec;
  end

endmodule

// File: rtl/enc823_req_queue.sv
// Captures event lines into a pending bitmap and presents them one at a time,
// highest index first, as binary codes over a valid/ready handshake.
module enc823_req_queue
  import enc_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [N-1:0]  req,
  output logic [CW-1:0] out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overflow,
  output logic [N-1:0]  pending
);

  logic [N-1:0]  pending_r;
  logic [CW-1:0] out_r;
  q_state_t      state_r;
  logic          overflow_r;

  logic          accept_s;
  logic [N-1:0]  clr_s;
  logic [N-1:0]  eff_s;
  logic [N-1:0]  cap_s;
  logic          hit_s;
  logic [CW-1:0] code_s;
  logic          any_s;

  // Transfer clear mask, surviving entries, and this cycle's captured events.
  always_comb begin
    accept_s = (state_r == PRESENT) & out_ready;
    if (accept_s) begin
      clr_s = {{(N-1){1'b0}}, 1'b1} << out_r;
    end else begin
      clr_s = {N{1'b0}};
    end
    eff_s = pending_r & ~clr_s;
    if (enable) begin
      cap_s = req;
    end else begin
      cap_s = {N{1'b0}};
    end
    hit_s = |(cap_s & eff_s);
  end

  prio_enc_comb #(.N(N), .CW(CW)) u_prio (
    .vec  (eff_s),
    .code (code_s),
    .any  (any_s)
  );

  // Pending bitmap, sticky overflow and the presented code.
  // Priority is taken from eff_s, so a new arrival never pre-empts a stalled code.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r  <= {N{1'b0}};
      out_r      <= {CW{1'b0}};
      state_r    <= EMPTY;
      overflow_r <= 1'b0;
    end else begin
      pending_r <= eff_s | cap_s;
      if (hit_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        EMPTY: begin
          out_r   <= code_s;
          state_r <= any_s ? PRESENT : EMPTY;
        end
        PRESENT: begin
          if (out_ready) begin
            out_r   <= code_s;
            state_r <= any_s ? PRESENT : EMPTY;
          end
        end
        default: begin
          out_r   <= {CW{1'b0}};
          state_r <= EMPTY;
        end
      endcase
    end
  end

  assign out       = out_r;
  assign out_valid = (state_r == PRESENT);
  assign overflow  = overflow_r;
  assign pending   = pending_r;

endmodule

// File: tb/tb_enc823_req_queue.sv
// Directed bench for enc823_req_queue: a queue-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_enc823_req_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] req;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model state
  bit [7:0] mpend = 8'h00;
  bit [7:0] mbase;
  bit       mv = 1'b0;
  int       mcode = 0;
  bit       movf = 1'b0;

  logic [7:0] pat_req [0:9] = '{8'h3C, 8'h00, 8'hA5, 8'h00, 8'h81,
                                8'h42, 8'h00, 8'h18, 8'hFF, 8'h00};

  enc823_req_queue dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: retire the accepted code, capture events, re-present from survivors.
  always @(posedge clk) begin
    if (reset) begin
      mpend = 8'h00;
      mv    = 1'b0;
      mcode = 0;
      movf  = 1'b0;
    end else begin
      mbase = mpend;
      if (mv && out_ready) mbase[mcode] = 1'b0;
      mpend = mbase;
      if (enable) begin
        for (int i = 0; i < 8; i++) begin
          if (req[i]) begin
            if (mbase[i]) movf = 1'b1;
            mpend[i] = 1'b1;
          end
        end
      end
      if (!mv || out_ready) begin
        mv    = 1'b0;
        mcode = 0;
        for (int i = 7; i >= 0; i--) begin
          if (mbase[i] && !mv) begin
            mv    = 1'b1;
            mcode = i;
          end
        end
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out_valid", int'(out_valid), int'(mv));
      if (mv) chk("model_out", int'(out), mcode);
      chk("model_pending", int'(pending), int'(mpend));
      chk("model_overflow", int'(overflow), int'(movf));
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; req = 8'hFF; out_ready = 1'b0;
    // 1: reset with all lines high
    step();
    chk_en = 1'b1;
    step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b0; req = 8'h00; out_ready = 1'b1;
    step();

    // 2: single event, two-edge latency
    req = 8'h04; step(); req = 8'h00;
    chk("t2_pending", int'(pending), 8'h04);
    chk("t2_valid_early", int'(out_valid), 0);
    step();
    chk("t2_valid", int'(out_valid), 1);
    chk("t2_out", int'(out), 2);
    step();
    chk("t2_drained", int'(out_valid), 0);
    chk("t2_pending_clr", int'(pending), 0);

    // 3: three events drain 7,4,1
    req = 8'h92; step(); req = 8'h00;
    chk("t3_pending", int'(pending), 8'h92);
    step(); chk("t3_out7", int'(out), 7);
    step(); chk("t3_out4", int'(out), 4);
    step(); chk("t3_out1", int'(out), 1);
    step(); chk("t3_empty", int'(out_valid), 0);

    // 4: stalled low code is not pre-empted
    out_ready = 1'b0;
    req = 8'h01; step(); req = 8'h00; step();
    chk("t4_out0", int'(out), 0);
    step();
    req = 8'h80; step(); req = 8'h00;
    chk("t4_pending", int'(pending), 8'h81);
    chk("t4_hold", int'(out), 0);
    step(); step();
    chk("t4_hold2", int'(out), 0);
    chk("t4_hold_valid", int'(out_valid), 1);
    out_ready = 1'b1; step();
    chk("t4_out7", int'(out), 7);
    step();
    chk("t4_empty", int'(out_valid), 0);

    // 5: repeat event on a pending line overflows, one code only
    out_ready = 1'b0;
    req = 8'h08; step(); req = 8'h00; step();
    chk("t5_out3", int'(out), 3);
    req = 8'h08; step(); req = 8'h00;
    chk("t5_ovf", int'(overflow), 1);
    out_ready = 1'b1; step();
    chk("t5_single", int'(out_valid), 0);
    chk("t5_pending", int'(pending), 0);
    step();
    chk("t5_sticky", int'(overflow), 1);

    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_ovf", int'(overflow), 0);

    // 6: event on the transfer edge of its own code
    out_ready = 1'b0;
    req = 8'h08; step(); req = 8'h00; step();
    chk("t6_out3", int'(out), 3);
    out_ready = 1'b1; req = 8'h08; step(); req = 8'h00;
    chk("t6_gap", int'(out_valid), 0);
    chk("t6_pending", int'(pending), 8'h08);
    chk("t6_no_ovf", int'(overflow), 0);
    step();
    chk("t6_again_valid", int'(out_valid), 1);
    chk("t6_again_out", int'(out), 3);
    step();

    // 7: enable low ignores req but drain continues
    out_ready = 1'b0;
    req = 8'h05; step(); req = 8'h00; step();
    chk("t7_out2", int'(out), 2);
    enable = 1'b0; req = 8'hFF; step(); step();
    chk("t7_pending", int'(pending), 8'h05);
    chk("t7_no_ovf", int'(overflow), 0);
    out_ready = 1'b1; step();
    chk("t7_out0", int'(out), 0);
    step();
    chk("t7_empty", int'(out_valid), 0);
    chk("t7_pend_empty", int'(pending), 0);
    enable = 1'b1; req = 8'h00;

    // 8: reset mid-handshake
    out_ready = 1'b0;
    req = 8'h10; step(); req = 8'h00; step();
    chk("t8_out4", int'(out), 4);
    reset = 1'b1; req = 8'hFF; step();
    chk("t8_valid", int'(out_valid), 0);
    chk("t8_pending", int'(pending), 0);
    reset = 1'b0; req = 8'h00; step();
    chk("t8_after", int'(out_valid), 0);

    // mixed traffic with irregular ready, checked by the model
    for (int k = 0; k < 30; k++) begin
      req       = pat_req[k % 10];
      out_ready = (k % 3 != 1);
      enable    = (k % 7 != 5);
      step();
    end
    req = 8'h00; out_ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("mix_drained", int'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
